// File: rtl/sb_hs_partner_responder.sv
// ============================================================================
// Module   : sb_hs_partner_responder
// Brief    : Sideband partner handshake responder. It matches a request against
//            a table of request/response pairs and drives the paired response
//            once the local TX path is idle. Optional macro SB_HS_RESP_RETRY_EN
//            lets a repeated request from COMPLETE re-send the response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_hs_partner_responder #(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int NUM_PAIRS      = 2,
    parameter logic [NUM_PAIRS*SB_MSG_WIDTH-1:0] REQ_CODES  = {4'd13, 4'd15},
    parameter logic [NUM_PAIRS*SB_MSG_WIDTH-1:0] RESP_CODES = {4'd12, 4'd14},
    parameter int TIMEOUT_CYCLES = 200,
    parameter int TIMEOUT_W      = 8,
    localparam int IDX_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [NUM_PAIRS-1:0]    i_pair_mask,
    input  logic                    i_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_Rx_SbMessage,
    input  logic                    i_module_valid,
    input  logic                    i_falling_edge_busy,
    output logic [SB_MSG_WIDTH-1:0] o_TX_SbMessage,
    output logic                    o_valid,
    output logic                    o_end,
    output logic [IDX_W-1:0]        o_pair_idx,
    output logic                    o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_WAIT_REQ      = 3'd1,
        S_WAIT_BUSY_CLR = 3'd2,
        S_SEND_RESP     = 3'd3,
        S_COMPLETE      = 3'd4,
        S_TIMEOUT       = 3'd5
    } state_t;

    localparam logic [TIMEOUT_W-1:0] C_TO_LAST =
        TIMEOUT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic C_TO_ENABLED = (TIMEOUT_CYCLES != 0);

    logic [SB_MSG_WIDTH-1:0] w_req_code  [NUM_PAIRS];
    logic [SB_MSG_WIDTH-1:0] w_resp_code [NUM_PAIRS];

    for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_codes
        assign w_req_code[g]  = REQ_CODES[g*SB_MSG_WIDTH +: SB_MSG_WIDTH];
        assign w_resp_code[g] = RESP_CODES[g*SB_MSG_WIDTH +: SB_MSG_WIDTH];
    end

    state_t                  r_state_q, w_state_d;
    logic [TIMEOUT_W-1:0]    r_cnt_q, w_cnt_d;
    logic [IDX_W-1:0]        r_idx_q, w_idx_d;
    logic [SB_MSG_WIDTH-1:0] r_tx_q, w_tx_d;
    logic                    r_valid_q, w_valid_d;
    logic                    r_end_q, w_end_d;
    logic                    r_timeout_q, w_timeout_d;

    logic                    w_hit;
    logic [IDX_W-1:0]        w_hit_idx;
    logic                    w_to_expire;

    // Descending scan so the lowest matching pair is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = NUM_PAIRS - 1; k >= 0; k--) begin
            if (i_msg_valid && (i_Rx_SbMessage == w_req_code[k]) && i_pair_mask[k]) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(k);
            end
        end
    end

`ifdef SB_HS_RESP_RETRY_EN
    logic w_same_hit;
    assign w_same_hit = i_msg_valid && (i_Rx_SbMessage == w_req_code[r_idx_q])
                        && i_pair_mask[r_idx_q];
`endif

    assign w_to_expire = C_TO_ENABLED && (r_cnt_q == C_TO_LAST);

    always_comb begin
        w_state_d = r_state_q;
        if (r_state_q != S_IDLE && !i_en) begin
            w_state_d = S_IDLE;
        end else begin
            case (r_state_q)
                S_IDLE: begin
                    if (i_en) w_state_d = S_WAIT_REQ;
                end
                S_WAIT_REQ: begin
                    if (w_hit)            w_state_d = S_WAIT_BUSY_CLR;
                    else if (w_to_expire) w_state_d = S_TIMEOUT;
                end
                S_WAIT_BUSY_CLR: begin
                    if (!i_module_valid) w_state_d = S_SEND_RESP;
                end
                S_SEND_RESP: begin
                    if (i_falling_edge_busy) w_state_d = S_COMPLETE;
                end
                S_COMPLETE: begin
`ifdef SB_HS_RESP_RETRY_EN
                    if (w_same_hit) w_state_d = S_WAIT_BUSY_CLR;
`else
                    w_state_d = S_COMPLETE;
`endif
                end
                S_TIMEOUT: w_state_d = S_TIMEOUT;
                default:   w_state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_d = '0;
        if (C_TO_ENABLED && r_state_q == S_WAIT_REQ && w_state_d == S_WAIT_REQ) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end

        w_idx_d = r_idx_q;
        if (w_state_d == S_IDLE) begin
            w_idx_d = '0;
        end else if (r_state_q == S_WAIT_REQ && w_state_d == S_WAIT_BUSY_CLR) begin
            w_idx_d = w_hit_idx;
        end

        // Outputs follow the next state so they line up with state entry.
        w_valid_d   = (w_state_d == S_SEND_RESP);
        w_end_d     = (w_state_d == S_COMPLETE);
        w_timeout_d = (w_state_d == S_TIMEOUT);
        w_tx_d      = w_valid_d ? w_resp_code[w_idx_d] : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state_q   <= S_IDLE;
            r_cnt_q     <= '0;
            r_idx_q     <= '0;
            r_tx_q      <= '0;
            r_valid_q   <= 1'b0;
            r_end_q     <= 1'b0;
            r_timeout_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_idx_q     <= w_idx_d;
            r_tx_q      <= w_tx_d;
            r_valid_q   <= w_valid_d;
            r_end_q     <= w_end_d;
            r_timeout_q <= w_timeout_d;
        end
    end

    assign o_TX_SbMessage = r_tx_q;
    assign o_valid        = r_valid_q;
    assign o_end          = r_end_q;
    assign o_pair_idx     = r_idx_q;
    assign o_timeout      = r_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_sb_hs_partner_responder.sv
// ============================================================================
// Module   : tb_sb_hs_partner_responder
// Brief    : Directed bench for sb_hs_partner_responder (timeout shortened to 10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sb_hs_partner_responder;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_en;
    logic [1:0] i_pair_mask;
    logic       i_msg_valid;
    logic [3:0] i_Rx_SbMessage;
    logic       i_module_valid;
    logic       i_falling_edge_busy;
    logic [3:0] o_TX_SbMessage;
    logic       o_valid;
    logic       o_end;
    logic [0:0] o_pair_idx;
    logic       o_timeout;

    int checks = 0;
    int passes = 0;

    sb_hs_partner_responder #(
        .SB_MSG_WIDTH  (4),
        .NUM_PAIRS     (2),
        .REQ_CODES     ({4'd13, 4'd15}),
        .RESP_CODES    ({4'd12, 4'd14}),
        .TIMEOUT_CYCLES(10),
        .TIMEOUT_W     (8)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_en               (i_en),
        .i_pair_mask        (i_pair_mask),
        .i_msg_valid        (i_msg_valid),
        .i_Rx_SbMessage     (i_Rx_SbMessage),
        .i_module_valid     (i_module_valid),
        .i_falling_edge_busy(i_falling_edge_busy),
        .o_TX_SbMessage     (o_TX_SbMessage),
        .o_valid            (o_valid),
        .o_end              (o_end),
        .o_pair_idx         (o_pair_idx),
        .o_timeout          (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Packs every output into one byte: {valid,end,timeout,idx,tx[3:0]}
    function automatic logic [7:0] outs();
        return {o_valid, o_end, o_timeout, o_pair_idx, o_TX_SbMessage};
    endfunction

    task automatic rx(input logic v, input logic [3:0] code);
        i_msg_valid    = v;
        i_Rx_SbMessage = code;
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_pair_mask = 2'b11;
        i_msg_valid = 1'b0; i_Rx_SbMessage = 4'd0;
        i_module_valid = 1'b0; i_falling_edge_busy = 1'b0;
        #3;
        check("reset_outs", outs(), 8'h00);
        tick();
        i_rst = 1'b0;

        // Basic handshake on pair 0
        i_en = 1'b1; tick();
        rx(1'b1, 4'd15); tick();
        check("basic_busyclr", outs(), 8'h00);
        rx(1'b0, 4'd0); tick();
        check("basic_send", outs(), 8'h8E);
        tick();
        check("basic_hold", outs(), 8'h8E);
        i_falling_edge_busy = 1'b1; tick();
        i_falling_edge_busy = 1'b0;
        check("basic_end", outs(), 8'h40);
        rx(1'b1, 4'd13); tick();
        check("complete_other_pair", outs(), 8'h40);
        rx(1'b1, 4'd15); tick();
        rx(1'b0, 4'd0);
`ifdef SB_HS_RESP_RETRY_EN
        check("retry_busyclr", outs(), 8'h00);
        tick();
        check("retry_send", outs(), 8'h8E);
`else
        check("complete_same_pair", outs(), 8'h40);
        tick();
        check("complete_hold", outs(), 8'h40);
`endif
        i_en = 1'b0; tick();
        check("basic_idle", outs(), 8'h00);

        // Busy wait on pair 1, then abort in SEND_RESP
        i_en = 1'b1; tick();
        i_module_valid = 1'b1;
        rx(1'b1, 4'd13); tick();
        rx(1'b0, 4'd0);
        check("busy_capture", outs(), 8'h10);
        for (int i = 0; i < 5; i++) begin
            i_falling_edge_busy = (i == 2);
            tick();
            check("busy_wait", outs(), 8'h10);
        end
        i_falling_edge_busy = 1'b0;
        i_module_valid = 1'b0; tick();
        check("pair1_send", outs(), 8'h9C);
        i_en = 1'b0; tick();
        check("abort_idle", outs(), 8'h00);

        // Masked pair 1 is ignored
        i_pair_mask = 2'b01;
        i_en = 1'b1; tick();
        rx(1'b1, 4'd13); tick();
        rx(1'b0, 4'd0); tick();
        check("mask_ignore", outs(), 8'h00);
        rx(1'b1, 4'd15); tick();
        rx(1'b0, 4'd0); tick();
        check("mask_pair0_send", outs(), 8'h8E);
        i_en = 1'b0; tick();
        i_pair_mask = 2'b11;

        // Timeout exactly 10 cycles after WAIT_REQ entry
        i_en = 1'b1; tick();
        for (int i = 0; i < 9; i++) tick();
        check("timeout_not_yet", outs(), 8'h00);
        tick();
        check("timeout_fire", outs(), 8'h20);
        tick();
        check("timeout_hold", outs(), 8'h20);
        i_en = 1'b0; tick();
        check("timeout_clear", outs(), 8'h00);

        // Hit on the 10th cycle beats the timeout
        i_en = 1'b1; tick();
        for (int i = 0; i < 9; i++) tick();
        rx(1'b1, 4'd15); tick();
        rx(1'b0, 4'd0);
        check("timeout_hit_wins", outs(), 8'h00);
        tick();
        check("timeout_hit_send", outs(), 8'h8E);
        i_en = 1'b0; tick();

        // Asynchronous reset in WAIT_BUSY_CLR
        i_en = 1'b1; tick();
        i_module_valid = 1'b1;
        rx(1'b1, 4'd13); tick();
        rx(1'b0, 4'd0);
        check("pre_reset_idx", outs(), 8'h10);
        #2 i_rst = 1'b1;
        #1 check("async_reset", outs(), 8'h00);
        tick();
        i_rst = 1'b0; i_module_valid = 1'b0; i_en = 1'b0;
        tick();
        check("post_reset_idle", outs(), 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
